// File: rtl/tile_scanner.sv
// tile_scanner: walks one tile in row-major order, stepping edge functions and z incrementally,
// and emits one fragment per covered pixel through a single output register.
`ifndef FX_TOTAL_BITS
`define FX_TOTAL_BITS 16
`endif
`ifndef FX_FRAC_BITS
`define FX_FRAC_BITS 4
`endif

package tile_scanner_pkg;
  localparam int COORD_BITS = `FX_TOTAL_BITS;
  typedef struct packed {
    logic signed [COORD_BITS-1:0] x;
    logic signed [COORD_BITS-1:0] y;
    logic signed [COORD_BITS-1:0] z;
  } coord_3d_t;
  typedef struct packed {
    logic [23:0] color;
    logic [7:0]  tile_idx;
  } metadata_t;
endpackage

module tile_scanner #(
  parameter int FX_TOTAL_BITS = `FX_TOTAL_BITS,
  parameter int FX_FRAC_BITS  = `FX_FRAC_BITS,
  parameter int TILE_W        = 8,
  parameter int TILE_H        = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                vld_in,
  output logic                                rdy_in,
  input  tile_scanner_pkg::coord_3d_t         in_abs_pos,
  input  tile_scanner_pkg::coord_3d_t         in_delta_0,
  input  tile_scanner_pkg::coord_3d_t         in_delta_1,
  input  tile_scanner_pkg::coord_3d_t         in_delta_2,
  input  logic signed [2*FX_TOTAL_BITS-1:0]   in_edge_0,
  input  logic signed [2*FX_TOTAL_BITS-1:0]   in_edge_1,
  input  logic signed [2*FX_TOTAL_BITS-1:0]   in_edge_2,
  input  logic signed [FX_TOTAL_BITS-1:0]     in_dzdx,
  input  logic signed [FX_TOTAL_BITS-1:0]     in_dzdy,
  input  logic signed [2*FX_TOTAL_BITS-1:0]   in_z_current,
  input  tile_scanner_pkg::metadata_t         in_metadata,
  output logic                                vld_out,
  input  logic                                rdy_out,
  output logic [FX_TOTAL_BITS-FX_FRAC_BITS-1:0] frag_x,
  output logic [FX_TOTAL_BITS-FX_FRAC_BITS-1:0] frag_y,
  output logic signed [2*FX_TOTAL_BITS-1:0]   frag_z,
  output tile_scanner_pkg::metadata_t         frag_metadata,
  output logic                                tile_done
);
  localparam int W2  = 2*FX_TOTAL_BITS;
  localparam int IW  = FX_TOTAL_BITS - FX_FRAC_BITS;
  localparam int LXW = $clog2(TILE_W);
  localparam int LYW = $clog2(TILE_H);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t state_q, state_d;
  logic vld_q, vld_d, done_q, done_d;
  logic [IW-1:0] org_x_q, org_x_d, org_y_q, org_y_d;
  logic [IW-1:0] frag_x_q, frag_x_d, frag_y_q, frag_y_d;
  logic signed [W2-1:0] frag_z_q, frag_z_d, cur_z_q, cur_z_d, row_z_q, row_z_d;
  logic signed [W2-1:0] dzdx_q, dzdx_d, dzdy_q, dzdy_d;
  logic signed [W2-1:0] cur_e_q [3];
  logic signed [W2-1:0] cur_e_d [3];
  logic signed [W2-1:0] row_e_q [3];
  logic signed [W2-1:0] row_e_d [3];
  logic signed [W2-1:0] step_x_q [3];
  logic signed [W2-1:0] step_x_d [3];
  logic signed [W2-1:0] step_y_q [3];
  logic signed [W2-1:0] step_y_d [3];
  logic signed [W2-1:0] in_e [3];
  tile_scanner_pkg::coord_3d_t in_d [3];
  tile_scanner_pkg::metadata_t meta_q, meta_d, frag_meta_q, frag_meta_d;
  logic [LXW-1:0] lx_q, lx_d;
  logic [LYW-1:0] ly_q, ly_d;
  logic accept, stall, covered, row_end;
  logic unused_ok;

  assign in_e = '{in_edge_0, in_edge_1, in_edge_2};
  assign in_d = '{in_delta_0, in_delta_1, in_delta_2};
  assign unused_ok = ^{in_abs_pos.z, in_abs_pos.x[FX_FRAC_BITS-1:0], in_abs_pos.y[FX_FRAC_BITS-1:0],
                       in_delta_0.z, in_delta_1.z, in_delta_2.z};

  assign rdy_in  = state_q == IDLE && !done_q;
  assign accept  = vld_in && rdy_in;
  assign stall   = vld_q && !rdy_out;
  assign covered = !(cur_e_q[0][W2-1] || cur_e_q[1][W2-1] || cur_e_q[2][W2-1]);
  assign row_end = lx_q == LXW'(TILE_W-1);

  assign vld_out       = vld_q;
  assign frag_x        = frag_x_q;
  assign frag_y        = frag_y_q;
  assign frag_z        = frag_z_q;
  assign frag_metadata = frag_meta_q;
  assign tile_done     = done_q;

  always_comb begin
    state_d     = state_q;
    vld_d       = vld_q;
    done_d      = 1'b0;
    org_x_d     = org_x_q;
    org_y_d     = org_y_q;
    frag_x_d    = frag_x_q;
    frag_y_d    = frag_y_q;
    frag_z_d    = frag_z_q;
    frag_meta_d = frag_meta_q;
    cur_z_d     = cur_z_q;
    row_z_d     = row_z_q;
    dzdx_d      = dzdx_q;
    dzdy_d      = dzdy_q;
    meta_d      = meta_q;
    lx_d        = lx_q;
    ly_d        = ly_q;
    for (int i = 0; i < 3; i++) begin
      cur_e_d[i]  = cur_e_q[i];
      row_e_d[i]  = row_e_q[i];
      step_x_d[i] = step_x_q[i];
      step_y_d[i] = step_y_q[i];
    end
    case (state_q)
      IDLE: if (accept) begin
        state_d = SCAN;
        org_x_d = in_abs_pos.x[FX_TOTAL_BITS-1:FX_FRAC_BITS];
        org_y_d = in_abs_pos.y[FX_TOTAL_BITS-1:FX_FRAC_BITS];
        dzdx_d  = W2'(in_dzdx);
        dzdy_d  = W2'(in_dzdy);
        cur_z_d = in_z_current;
        row_z_d = in_z_current;
        meta_d  = in_metadata;
        lx_d    = '0;
        ly_d    = '0;
        // Row stepping subtracts delta.x, so store it pre-negated and always add.
        for (int i = 0; i < 3; i++) begin
          cur_e_d[i]  = in_e[i];
          row_e_d[i]  = in_e[i];
          step_x_d[i] = W2'(in_d[i].y) <<< FX_FRAC_BITS;
          step_y_d[i] = -(W2'(in_d[i].x) <<< FX_FRAC_BITS);
        end
      end
      SCAN: if (!stall) begin
        vld_d       = covered;
        frag_x_d    = covered ? org_x_q + IW'(lx_q) : frag_x_q;
        frag_y_d    = covered ? org_y_q + IW'(ly_q) : frag_y_q;
        frag_z_d    = covered ? cur_z_q : frag_z_q;
        frag_meta_d = covered ? meta_q : frag_meta_q;
        cur_z_d     = row_end ? row_z_q + dzdy_q : cur_z_q + dzdx_q;
        row_z_d     = row_end ? row_z_q + dzdy_q : row_z_q;
        for (int i = 0; i < 3; i++) begin
          cur_e_d[i] = row_end ? row_e_q[i] + step_y_q[i] : cur_e_q[i] + step_x_q[i];
          row_e_d[i] = row_end ? row_e_q[i] + step_y_q[i] : row_e_q[i];
        end
        lx_d    = lx_q + 1'b1;
        ly_d    = ly_q + LYW'(row_end);
        state_d = row_end && ly_q == LYW'(TILE_H-1) ? DRAIN : SCAN;
      end
      DRAIN: if (!stall) begin
        vld_d   = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      vld_q       <= 1'b0;
      done_q      <= 1'b0;
      frag_x_q    <= '0;
      frag_y_q    <= '0;
      frag_z_q    <= '0;
      frag_meta_q <= '0;
    end else begin
      state_q     <= state_d;
      vld_q       <= vld_d;
      done_q      <= done_d;
      frag_x_q    <= frag_x_d;
      frag_y_q    <= frag_y_d;
      frag_z_q    <= frag_z_d;
      frag_meta_q <= frag_meta_d;
    end
  end

  always_ff @(posedge clk) begin
    org_x_q <= org_x_d;
    org_y_q <= org_y_d;
    cur_z_q <= cur_z_d;
    row_z_q <= row_z_d;
    dzdx_q  <= dzdx_d;
    dzdy_q  <= dzdy_d;
    meta_q  <= meta_d;
    lx_q    <= lx_d;
    ly_q    <= ly_d;
    for (int i = 0; i < 3; i++) begin
      cur_e_q[i]  <= cur_e_d[i];
      row_e_q[i]  <= row_e_d[i];
      step_x_q[i] <= step_x_d[i];
      step_y_q[i] <= step_y_d[i];
    end
  end
endmodule

// File: tb/tb_tile_scanner.sv
// tb_tile_scanner: randomized scoreboard bench; expected fragments come from a closed-form
// per-pixel model (E = E0 + lx*dy*2^F - ly*dx*2^F, z = z0 + lx*dzdx + ly*dzdy).
module tb_tile_scanner;
  import tile_scanner_pkg::*;

  typedef struct {
    logic [11:0]        x;
    logic [11:0]        y;
    logic signed [31:0] z;
    metadata_t          m;
  } frag_t;

  logic clk = 1'b0;
  logic rst, vld_in, rdy_in, rdy_out, vld_out, tile_done;
  coord_3d_t abs_pos, d0, d1, d2;
  logic signed [31:0] e0, e1, e2, zc, frag_z;
  logic signed [15:0] dzdx, dzdy;
  metadata_t meta, frag_metadata;
  logic [11:0] frag_x, frag_y;

  frag_t exp_q[$];
  int vectors = 0, miscompares = 0;
  int done_cnt = 0, tile_frags = 0, rdy_mode = 0, stall_n = 0;

  always #5 clk = ~clk;

  tile_scanner #(.FX_TOTAL_BITS(16), .FX_FRAC_BITS(4), .TILE_W(4), .TILE_H(4)) dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_in(rdy_in),
    .in_abs_pos(abs_pos), .in_delta_0(d0), .in_delta_1(d1), .in_delta_2(d2),
    .in_edge_0(e0), .in_edge_1(e1), .in_edge_2(e2),
    .in_dzdx(dzdx), .in_dzdy(dzdy), .in_z_current(zc), .in_metadata(meta),
    .vld_out(vld_out), .rdy_out(rdy_out), .frag_x(frag_x), .frag_y(frag_y),
    .frag_z(frag_z), .frag_metadata(frag_metadata), .tile_done(tile_done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  initial begin
    logic prev_stall;
    logic [11:0] px, py;
    logic signed [31:0] pz;
    frag_t f;
    prev_stall = 1'b0;
    px = '0; py = '0; pz = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        prev_stall = 1'b0;
        tile_frags = 0;
      end else begin
        if (prev_stall) begin
          chk("hold_vld", 64'(vld_out), 64'd1);
          chk("hold_xyz", {frag_x, frag_y, frag_z}, {px, py, pz});
        end
        if (vld_out && rdy_out) begin
          if (exp_q.size() == 0) chk("extra_frag", {frag_x, frag_y}, 64'hFFFFFFFF);
          else begin
            f = exp_q.pop_front();
            chk("frag_x", 64'(frag_x), 64'(f.x));
            chk("frag_y", 64'(frag_y), 64'(f.y));
            chk("frag_z", 64'(frag_z), 64'(f.z));
            chk("frag_meta", 64'(frag_metadata), 64'(f.m));
          end
          tile_frags++;
        end
        if (tile_done) begin
          chk("left_frags", 64'(exp_q.size()), 64'd0);
          chk("done_vld_out", 64'(vld_out), 64'd0);
          done_cnt++;
          tile_frags = 0;
        end
        prev_stall = vld_out && !rdy_out;
        px = frag_x; py = frag_y; pz = frag_z;
      end
    end
  end

  // Downstream ready: always high, random, or a 5-cycle stall while fragment 3 is presented.
  initial begin
    rdy_out = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) rdy_out = $urandom_range(0, 3) != 0;
      else if (rdy_mode == 2 && tile_frags == 2 && stall_n < 5) begin
        rdy_out = 1'b0;
        stall_n++;
      end else begin
        rdy_out = 1'b1;
        if (rdy_mode != 2) stall_n = 0;
      end
    end
  end

  task automatic set_full(input logic signed [31:0] z0);
    abs_pos = '{x: 16'sd64, y: 16'sd0, z: 16'sd0};
    d0 = '0; d1 = '0; d2 = '0;
    e0 = 32'sd1000; e1 = 32'sd1000; e2 = 32'sd1000;
    dzdx = '0; dzdy = '0; zc = z0;
    meta = metadata_t'($urandom);
  endtask

  task automatic run_tile(input bit check_lat, input int abort_at);
    int t, lat, dc;
    frag_t f;
    for (int ly = 0; ly < 4; ly++)
      for (int lx = 0; lx < 4; lx++) begin
        int a, b, c;
        a = e0 + lx * (int'(d0.y) * 16) - ly * (int'(d0.x) * 16);
        b = e1 + lx * (int'(d1.y) * 16) - ly * (int'(d1.x) * 16);
        c = e2 + lx * (int'(d2.y) * 16) - ly * (int'(d2.x) * 16);
        if (a >= 0 && b >= 0 && c >= 0) begin
          f.x = abs_pos.x[15:4] + 12'(lx);
          f.y = abs_pos.y[15:4] + 12'(ly);
          f.z = zc + lx * int'(dzdx) + ly * int'(dzdy);
          f.m = meta;
          exp_q.push_back(f);
        end
      end
    t = 0;
    while (!rdy_in && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("rdy_in_wait", 64'(rdy_in), 64'd1);
    @(posedge clk); #1 vld_in = 1'b1;
    @(posedge clk); #1 vld_in = 1'b0;
    e0 = 32'($urandom); e1 = 32'($urandom); e2 = 32'($urandom);
    abs_pos = coord_3d_t'({$urandom, 16'($urandom)});
    zc = 32'($urandom); dzdx = 16'($urandom); meta = metadata_t'($urandom);
    if (abort_at > 0) begin
      repeat (abort_at) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_vld_out", 64'(vld_out), 64'd0);
      chk("rst_rdy_in", 64'(rdy_in), 64'd1);
      dc = done_cnt;
      repeat (25) @(negedge clk);
      chk("rst_no_done", 64'(done_cnt), 64'(dc));
      return;
    end
    lat = 0;
    while (lat < 400) begin
      @(negedge clk);
      if (tile_done) break;
      lat++;
    end
    if (lat >= 400) chk("done_timeout", 64'(lat), 64'd0);
    else begin
      if (check_lat) chk("done_latency", 64'(lat), 64'd17);
      chk("rdy_in_during_done", 64'(rdy_in), 64'd0);
      @(negedge clk);
      chk("rdy_in_after_done", 64'(rdy_in), 64'd1);
      chk("done_one_cycle", 64'(tile_done), 64'd0);
    end
  endtask

  initial begin
    rst = 1'b1; vld_in = 1'b0;
    set_full(32'sd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_vld_out", 64'(vld_out), 64'd0);
    chk("reset_tile_done", 64'(tile_done), 64'd0);
    chk("reset_frag_x", 64'(frag_x), 64'd0);
    chk("reset_frag_y", 64'(frag_y), 64'd0);
    chk("reset_frag_z", 64'(frag_z), 64'd0);
    chk("reset_frag_meta", 64'(frag_metadata), 64'd0);
    chk("reset_rdy_in", 64'(rdy_in), 64'd1);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_rdy_in", 64'(rdy_in), 64'd1);
      chk("idle_vld_out", 64'(vld_out), 64'd0);
    end
    set_full(32'sd500); run_tile(1, 0);
    set_full(32'sd500); e0 = -32'sd1; run_tile(1, 0);
    set_full(32'sd500); e0 = 32'sd0; d0.y = -16'sd16; e1 = 32'sd100000; e2 = 32'sd100000; run_tile(1, 0);
    set_full(32'sd1000); dzdx = 16'sd16; dzdy = 16'sd64; run_tile(1, 0);
    rdy_mode = 2; set_full(32'sd7); run_tile(0, 0); rdy_mode = 0;
    set_full(32'sd9); run_tile(0, 6);
    rdy_mode = 1;
    for (int n = 0; n < 40; n++) begin
      abs_pos = coord_3d_t'({$urandom, 16'($urandom)});
      e0 = 32'($urandom_range(0, 6000)) - 32'sd3000;
      e1 = 32'($urandom_range(0, 6000)) - 32'sd3000;
      e2 = 32'($urandom_range(0, 6000)) - 32'sd3000;
      d0 = '{x: 16'($urandom_range(0, 300)) - 16'sd150, y: 16'($urandom_range(0, 300)) - 16'sd150, z: 16'($urandom)};
      d1 = '{x: 16'($urandom_range(0, 300)) - 16'sd150, y: 16'($urandom_range(0, 300)) - 16'sd150, z: 16'($urandom)};
      d2 = '{x: 16'($urandom_range(0, 300)) - 16'sd150, y: 16'($urandom_range(0, 300)) - 16'sd150, z: 16'($urandom)};
      zc = 32'($urandom); dzdx = 16'($urandom); dzdy = 16'($urandom);
      meta = metadata_t'($urandom);
      run_tile(0, 0);
    end
    rdy_mode = 0;
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
    $fatal(1, "watchdog expired");
  end
endmodule
